// File: rtl/keypad_pkg.sv
// keypad_pkg: shared FSM state type, idle row constant and key-code helper
// for the 4x4 keypad scanner.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    localparam logic [3:0] ROW_IDLE = 4'b1111;

    // Lowest-index active-low row wins when several rows are pulled low.
    function automatic logic [3:0] code_of(input logic [3:0] row, input logic [1:0] col);
        logic [1:0] r;
        r = 2'd3;
        for (int i = 3; i >= 0; i--) begin
            if (!row[i]) r = 2'(i);
        end
        return {r, col};
    endfunction

endpackage

// File: rtl/keypad_scanner_4x4_if.sv
// keypad_scanner_4x4_if: keypad matrix pins and decoded key outputs.
// master = scanner side, slave = keypad/consumer side.
interface keypad_scanner_4x4_if;
    logic [3:0] Row;
    logic [3:0] Col;
    logic [3:0] Key;
    logic       Key_Valid;
    logic       Key_Held;

    modport master (input Row, output Col, output Key, output Key_Valid, output Key_Held);
    modport slave  (output Row, input Col, input Key, input Key_Valid, input Key_Held);
endinterface

// File: rtl/keypad_debounce.sv
// keypad_debounce: 2-flop row synchronizer plus a saturating counter of
// consecutive cycles on which the synchronized row equals a reference pattern.
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_CNT = 20000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row_async,
    input  logic       en,
    input  logic [3:0] ref_pat,
    output logic [3:0] row,
    output logic       match,
    output logic       done
);
    localparam int CW = $clog2(DEBOUNCE_CNT);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CNT - 1);

    logic [3:0]    row_p0, row_p1;
    logic [CW-1:0] cnt;

    assign row   = row_p1;
    assign match = en && (row_p1 == ref_pat);
    // done marks the DEBOUNCE_CNT-th consecutive matching cycle
    assign done  = match && (cnt == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_p0 <= ROW_IDLE;
            row_p1 <= ROW_IDLE;
            cnt    <= '0;
        end else begin
            row_p0 <= row_async;
            row_p1 <= row_p0;
            if (!match)
                cnt <= '0;
            else if (cnt != CNT_LAST)
                cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/keypad_scanner_4x4.sv
// keypad_scanner_4x4: one-cold column scanner with debounced press/release FSM.
// Define KEYPAD_SCANNER_REPEAT_EN to add typematic repeat of Key_Valid while a key is held.
module keypad_scanner_4x4
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CNT = 20000
`ifdef KEYPAD_SCANNER_REPEAT_EN
    ,
    parameter int REPEAT_DELAY = 500000,
    parameter int REPEAT_RATE  = 100000
`endif
) (
    input logic                  Clk,
    input logic                  Reset,
    keypad_scanner_4x4_if.master kp
);
    localparam int DW = $clog2(SCAN_DIV);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);

    state_t        state, state_nx;
    logic [1:0]    col_idx, col_nx;
    logic [DW-1:0] dwell, dwell_nx;
    logic [3:0]    cap, cap_nx;
    logic [3:0]    key, key_nx;
    logic          kv, kv_nx, kv_d;
    logic [3:0]    row;
    logic          db_en, db_match, db_done;
    logic [3:0]    db_ref;

    // Press confirmation compares against the captured pattern, release against idle.
    assign db_en  = (state == DEBOUNCE) || (state == RELEASE);
    assign db_ref = (state == DEBOUNCE) ? cap : ROW_IDLE;

    keypad_debounce #(
        .DEBOUNCE_CNT(DEBOUNCE_CNT)
    ) u_debounce (
        .clk      (Clk),
        .rst      (Reset),
        .row_async(kp.Row),
        .en       (db_en),
        .ref_pat  (db_ref),
        .row      (row),
        .match    (db_match),
        .done     (db_done)
    );

    always_comb begin
        state_nx = state;
        col_nx   = col_idx;
        dwell_nx = '0;
        cap_nx   = cap;
        key_nx   = key;
        kv_nx    = 1'b0;
        unique case (state)
            SCAN: begin
                if (dwell != DWELL_LAST) begin
                    dwell_nx = dwell + 1'b1;
                end else if (row != ROW_IDLE) begin
                    cap_nx   = row;
                    state_nx = DEBOUNCE;
                end else begin
                    col_nx = col_idx + 2'd1;
                end
            end
            DEBOUNCE: begin
                if (db_done) begin
                    key_nx   = code_of(cap, col_idx);
                    kv_nx    = 1'b1;
                    state_nx = PRESSED;
                end else if (!db_match) begin
                    state_nx = SCAN;
                    col_nx   = col_idx + 2'd1;
                end
            end
            PRESSED: begin
                if (row == ROW_IDLE) state_nx = RELEASE;
            end
            RELEASE: begin
                if (db_done) begin
                    state_nx = SCAN;
                    col_nx   = col_idx + 2'd1;
                end else if (!db_match) begin
                    state_nx = PRESSED;
                end
            end
            default: state_nx = SCAN;
        endcase
    end

`ifdef KEYPAD_SCANNER_REPEAT_EN
    // Assumes REPEAT_DELAY >= REPEAT_RATE so one counter width covers both intervals.
    localparam int RW = $clog2(REPEAT_DELAY);

    logic [RW-1:0] rep_cnt, rep_cnt_nx;
    logic          rep_first, rep_first_nx, rep_fire;

    always_comb begin
        rep_cnt_nx   = '0;
        rep_first_nx = 1'b1;
        rep_fire     = 1'b0;
        if (state == PRESSED && state_nx == PRESSED) begin
            rep_first_nx = rep_first;
            if (rep_cnt == (rep_first ? RW'(REPEAT_DELAY - 1) : RW'(REPEAT_RATE - 1))) begin
                rep_fire     = 1'b1;
                rep_first_nx = 1'b0;
            end else begin
                rep_cnt_nx = rep_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            rep_cnt   <= '0;
            rep_first <= 1'b1;
        end else begin
            rep_cnt   <= rep_cnt_nx;
            rep_first <= rep_first_nx;
        end
    end

    assign kv_d = kv_nx | rep_fire;
`else
    assign kv_d = kv_nx;
`endif

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state   <= SCAN;
            col_idx <= '0;
            dwell   <= '0;
            cap     <= ROW_IDLE;
            key     <= '0;
            kv      <= 1'b0;
        end else begin
            state   <= state_nx;
            col_idx <= col_nx;
            dwell   <= dwell_nx;
            cap     <= cap_nx;
            key     <= key_nx;
            kv      <= kv_d;
        end
    end

    assign kp.Col       = ~(4'b0001 << col_idx);
    assign kp.Key       = key;
    assign kp.Key_Valid = kv;
    assign kp.Key_Held  = (state == PRESSED) || (state == RELEASE);
endmodule

// File: tb/tb_keypad_scanner_4x4.sv
// tb_keypad_scanner_4x4: keypad matrix model driving the scanner, table vectors,
// directed corner sequences and random presses checked against a reference model.
module tb_keypad_scanner_4x4;
    localparam int SCAN_DIV     = 4;
    localparam int DEBOUNCE_CNT = 8;
`ifdef KEYPAD_SCANNER_REPEAT_EN
    localparam int REPEAT_DELAY = 40;
    localparam int REPEAT_RATE  = 16;
`endif

    logic        Clk = 1'b0;
    logic        Reset;
    logic [15:0] pressed;
    logic        force_en;
    logic [3:0]  force_row;
    int          checks = 0;
    int          failures = 0;

    keypad_scanner_4x4_if kp ();

    always #5 Clk = ~Clk;

    // Physical keypad: a pressed key at (r,c) pulls row r low while column c is strobed.
    function automatic logic [3:0] matrix_row(input logic [15:0] k, input logic [3:0] col);
        logic [3:0] r;
        r = 4'hF;
        for (int i = 0; i < 16; i++) begin
            if (k[i] && !col[i % 4]) r[i / 4] = 1'b0;
        end
        return r;
    endfunction

    assign kp.Row = force_en ? force_row : matrix_row(pressed, kp.Col);

`ifdef KEYPAD_SCANNER_REPEAT_EN
    keypad_scanner_4x4 #(
        .SCAN_DIV(SCAN_DIV), .DEBOUNCE_CNT(DEBOUNCE_CNT),
        .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)
    ) dut (.Clk(Clk), .Reset(Reset), .kp(kp));
`else
    keypad_scanner_4x4 #(
        .SCAN_DIV(SCAN_DIV), .DEBOUNCE_CNT(DEBOUNCE_CNT)
    ) dut (.Clk(Clk), .Reset(Reset), .kp(kp));
`endif

    // Reference model: synchronizer as a sample queue, behaviour by phase and elapsed time.
    typedef enum int {M_SCAN, M_CONFIRM, M_HELD, M_RELEASING} phase_t;
    phase_t     ph;
    int         m_col, m_elapsed, m_run, m_age;
    logic [3:0] m_pat, m_key;
    logic       m_kv, m_held;
    logic [3:0] rawq[$];

    function automatic int lowest_low(input logic [3:0] r);
        int idx;
        idx = 0;
        for (int i = 3; i >= 0; i--) if (!r[i]) idx = i;
        return idx;
    endfunction

    task automatic model_reset();
        ph = M_SCAN; m_col = 0; m_elapsed = 0; m_run = 0; m_age = 0;
        m_pat = 4'hF; m_key = 4'h0; m_kv = 1'b0; m_held = 1'b0;
        rawq = '{4'hF, 4'hF};
    endtask

    task automatic model_tick(input logic [3:0] raw);
        logic [3:0] s;
        s = rawq.pop_front();
        rawq.push_back(raw);
        m_kv = 1'b0;
        case (ph)
            M_SCAN: begin
                m_elapsed++;
                if (m_elapsed == SCAN_DIV) begin
                    m_elapsed = 0;
                    if (s != 4'hF) begin m_pat = s; m_run = 0; ph = M_CONFIRM; end
                    else m_col = (m_col + 1) % 4;
                end
            end
            M_CONFIRM: begin
                if (s == m_pat) begin
                    m_run++;
                    if (m_run == DEBOUNCE_CNT) begin
                        m_key = 4'(lowest_low(m_pat) * 4 + m_col);
                        m_kv = 1'b1; m_age = 0; ph = M_HELD;
                    end
                end else begin
                    ph = M_SCAN; m_col = (m_col + 1) % 4; m_elapsed = 0;
                end
            end
            M_HELD: begin
                if (s == 4'hF) begin
                    ph = M_RELEASING; m_run = 0;
                end else begin
                    m_age++;
`ifdef KEYPAD_SCANNER_REPEAT_EN
                    if (m_age >= REPEAT_DELAY && (m_age - REPEAT_DELAY) % REPEAT_RATE == 0) m_kv = 1'b1;
`endif
                end
            end
            M_RELEASING: begin
                if (s == 4'hF) begin
                    m_run++;
                    if (m_run == DEBOUNCE_CNT) begin
                        ph = M_SCAN; m_col = (m_col + 1) % 4; m_elapsed = 0;
                    end
                end else begin
                    ph = M_HELD; m_age = 0;
                end
            end
            default: ph = M_SCAN;
        endcase
        m_held = (ph == M_HELD) || (ph == M_RELEASING);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: sample Row mid-cycle, advance the model, compare just after the edge.
    task automatic step();
        logic [3:0] raw, ec;
        @(negedge Clk);
        raw = kp.Row;
        @(posedge Clk);
        #1;
        if (Reset) model_reset();
        else model_tick(raw);
        ec = ~(4'b0001 << m_col);
        checks++;
        if (kp.Col !== ec || kp.Key !== m_key || kp.Key_Valid !== m_kv || kp.Key_Held !== m_held) begin
            failures++;
            $display("FAIL model t=%0t col=%b/%b key=%h/%h valid=%b/%b held=%b/%b (dut/ref)",
                     $time, kp.Col, ec, kp.Key, m_key, kp.Key_Valid, m_kv, kp.Key_Held, m_held);
        end
    endtask

    typedef struct {
        logic [15:0] keys;
        int          hold;
        logic [3:0]  exp_key;
        int          exp_pulses;
    } vec_t;
    vec_t tbl[7];

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] ec;
        int pulses, got, lat, kind, dur, gap;

        tbl[0] = '{16'h0200, 30, 4'h9, 1};
        tbl[1] = '{16'h8008, 30, 4'h3, 1};
        tbl[2] = '{16'h0001, 30, 4'h0, 1};
        tbl[3] = '{16'h4000, 30, 4'hE, 1};
        tbl[4] = '{16'h0040, 3,  4'hE, 0};
        tbl[5] = '{16'h0220, 30, 4'h5, 1};
        tbl[6] = '{16'h0080, 30, 4'h7, 1};

        pressed = '0; force_en = 1'b0; force_row = 4'hF; Reset = 1'b1;
        model_reset();
        repeat (3) @(posedge Clk);
        #1;
        check("rst_col", kp.Col, 4'b1110);
        check("rst_key", kp.Key, 4'h0);
        check("rst_valid", kp.Key_Valid, 1'b0);
        check("rst_held", kp.Key_Held, 1'b0);
        Reset = 1'b0;

        // Idle scanning: column index = floor(cycle / SCAN_DIV) mod 4.
        pulses = 0;
        for (int n = 1; n <= 64; n++) begin
            step();
            ec = ~(4'b0001 << ((n / SCAN_DIV) % 4));
            check("idle_col", kp.Col, ec);
            if (kp.Key_Valid) pulses++;
        end
        check("idle_pulses", pulses, 0);

        for (int v = 0; v < 7; v++) begin
            pulses = 0;
            pressed = tbl[v].keys;
            for (int c = 0; c < tbl[v].hold; c++) begin step(); if (kp.Key_Valid) pulses++; end
            pressed = '0;
            for (int c = 0; c < 40; c++) begin step(); if (kp.Key_Valid) pulses++; end
            check($sformatf("vec%0d_pulses", v), pulses, tbl[v].exp_pulses);
            check($sformatf("vec%0d_key", v), kp.Key, tbl[v].exp_key);
            check($sformatf("vec%0d_held", v), kp.Key_Held, 1'b0);
        end

        // Short glitch on Row[1]: never accepted, scanning continues.
        pulses = 0; got = 0;
        force_en = 1'b1; force_row = 4'b1101;
        for (int c = 0; c < 5; c++) begin step(); if (kp.Key_Valid) pulses++; end
        force_en = 1'b0;
        for (int c = 0; c < 30; c++) begin step(); if (kp.Key_Valid) pulses++; if (kp.Key_Held) got = 1; end
        check("glitch_pulses", pulses, 0);
        check("glitch_held", got, 0);

        // Reset while PRESSED, then re-acceptance of the still-held key from column 0.
        pressed = 16'h1000;
        got = 0;
        for (int c = 0; c < 100 && got == 0; c++) begin step(); if (kp.Key_Held) got = 1; end
        check("pre_rst_pressed", got, 1);
        check("pre_rst_key", kp.Key, 4'hC);
        #2; Reset = 1'b1; #1;
        check("async_rst_col", kp.Col, 4'b1110);
        check("async_rst_key", kp.Key, 4'h0);
        check("async_rst_held", kp.Key_Held, 1'b0);
        model_reset();
        step(); step();
        Reset = 1'b0;
        lat = 0;
        for (int c = 1; c <= 100 && lat == 0; c++) begin step(); if (kp.Key_Valid) lat = c; end
        check("reaccept_latency", lat, SCAN_DIV + DEBOUNCE_CNT);
        check("reaccept_key", kp.Key, 4'hC);
        pressed = '0;
        repeat (40) step();

        // Long hold after acceptance.
        pressed = 16'h0200;
        got = 0;
        for (int c = 0; c < 60 && got == 0; c++) begin step(); if (kp.Key_Valid) got = 1; end
        check("long_accept", got, 1);
`ifdef KEYPAD_SCANNER_REPEAT_EN
        for (int age = 1; age <= 100; age++) begin
            step();
            check($sformatf("repeat_age%0d", age), kp.Key_Valid,
                  (age == 40 || age == 56 || age == 72 || age == 88) ? 1 : 0);
        end
`else
        pulses = 0;
        for (int age = 1; age <= 150; age++) begin step(); if (kp.Key_Valid) pulses++; end
        check("no_repeat_pulses", pulses, 0);
`endif
        check("long_key", kp.Key, 4'h9);
        pressed = '0;
        repeat (40) step();
        check("long_released", kp.Key_Held, 1'b0);

        // Random presses, glitches and multi-key combinations against the model.
        for (int e = 0; e < 40; e++) begin
            kind = int'($urandom_range(0, 3));
            if (kind == 0) begin
                force_en = 1'b1; force_row = 4'($urandom_range(0, 15));
            end else begin
                pressed = 16'(1 << $urandom_range(0, 15));
                if (kind == 3) pressed = pressed | 16'(1 << $urandom_range(0, 15));
            end
            dur = int'($urandom_range(1, 45));
            repeat (dur) step();
            force_en = 1'b0; pressed = '0;
            gap = int'($urandom_range(0, 30));
            repeat (gap) step();
        end
        repeat (40) step();
        check("final_held", kp.Key_Held, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/keypad_scanner_4x4.md
KEYPAD_SCANNER_4X4 -- requirements
Module: keypad_scanner_4x4

Interface
REQ-001 Parameter SCAN_DIV, default 1000: clock cycles each column strobe is held (dwell), minimum 4.
REQ-002 Parameter DEBOUNCE_CNT, default 20000: consecutive stable cycles required to accept a press or a release, minimum 2.
REQ-003 Clk  input  1  system clock; all logic is on the rising edge.
REQ-004 Reset  input  1  asynchronous, active-high reset.
REQ-005 Row  input  4  keypad row lines, active-low, externally pulled up, asynchronous to Clk.
REQ-006 Col  output  4  column strobes, one-cold: exactly one bit is low at all times.
REQ-007 Key  output  4  code of the last accepted key, where code = row_index*4 + col_index.
REQ-008 Key_Valid  output  1  one-cycle pulse in the same cycle Key takes a new accepted value.
REQ-009 Key_Held  output  1  high while an accepted key remains pressed.

Function
REQ-010 Row SHALL pass through a 2-flop synchronizer before any use; "row" below means the synchronized value.
REQ-011 The FSM SHALL have exactly four states: SCAN, DEBOUNCE, PRESSED and RELEASE.
REQ-012 In SCAN, the active column index SHALL advance 0->1->2->3->0 every SCAN_DIV cycles, with Col = ~(1<<index).
REQ-013 On the last dwell cycle of a column, if row != 4'b1111, the FSM SHALL capture the row pattern, freeze the column and enter DEBOUNCE; otherwise scanning continues.
REQ-014 In DEBOUNCE, a counter SHALL increment each cycle the row equals the captured pattern; any mismatch, including all-ones, SHALL clear the counter and return to SCAN at the next column.
REQ-015 When the counter reaches DEBOUNCE_CNT, the block SHALL update Key, pulse Key_Valid for one cycle and enter PRESSED.
REQ-016 If several row bits are low, the lowest-index low row SHALL determine the code.
REQ-017 In PRESSED, Key_Held SHALL be 1 and Col stays frozen; row = 4'b1111 SHALL move the FSM to RELEASE.
REQ-018 In RELEASE, DEBOUNCE_CNT consecutive all-ones cycles SHALL clear Key_Held and return to SCAN at the next column; any low row bit SHALL return the FSM to PRESSED with no new Key_Valid.
REQ-019 Key SHALL keep its last accepted value through release and later scanning.
REQ-020 Counters SHALL be sized with $clog2 of their parameter and SHALL saturate, never wrap, in any state.

Reset
REQ-021 While Reset is high, the block SHALL hold: state SCAN, column index 0, Col = 4'b1110, Key = 4'h0, Key_Valid = 0, Key_Held = 0, all counters 0, synchronizer flops 1.
REQ-022 Reset asserted in any state SHALL take effect immediately; after release, scanning SHALL restart from column 0 with a full dwell.

Configuration
REQ-023 Macro KEYPAD_SCANNER_REPEAT_EN, when defined, SHALL add parameters REPEAT_DELAY (default 500000) and REPEAT_RATE (default 100000).
REQ-024 With the macro defined, while in PRESSED, Key_Valid SHALL re-pulse with an unchanged Key after REPEAT_DELAY cycles and then every REPEAT_RATE cycles until the FSM leaves PRESSED.
REQ-025 Without the macro, exactly one Key_Valid pulse SHALL occur per accepted press, and no repeat logic SHALL be synthesized.

Structure
REQ-026 Package keypad_pkg SHALL hold the FSM state enum, the code-from-row/column function and the all-ones idle constant.
REQ-027 The synchronizer plus stable-count logic SHALL be one sub-module, keypad_debounce, instantiated once.
REQ-028 Col SHALL remain drivable into the existing one-cold column convention used by the display multiplexer; no shared-pin arbitration is in scope.

Verification (SCAN_DIV=4, DEBOUNCE_CNT=8, REPEAT_DELAY=40, REPEAT_RATE=16)
REQ-029 No key pressed for 64 cycles after reset -> Col cycles 1110,1101,1011,0111 every 4 cycles; Key_Valid never asserts.
REQ-030 Row[2] held low while Col=1101 for 30 cycles -> one Key_Valid pulse with Key=4'h9; Key_Held=1 until 8 cycles after release.
REQ-031 Row[1] low for 5 cycles only -> no Key_Valid; scanning resumes at the next column.
REQ-032 Row[3] and Row[0] low together on column 3 -> Key=4'h3.
REQ-033 Reset pulsed while in PRESSED -> Col=1110, Key=0, Key_Held=0 immediately; after Reset deasserts, a still-held key is re-accepted from column 0.
REQ-034 With the macro defined, key held for 100 cycles after acceptance -> extra Key_Valid pulses at +40, +56, +72 and +88 cycles.
